// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path.
//   DATA_W    register / WD3 width
//   ADDR_W    register address width (NUM_REGS registers, r0 reads as zero)
//   CNT_W     width of the per-register pending-write counters
//   wb_entry_t  one queued writeback: {addr, data}
package regfile_pkg;

    localparam int unsigned DATA_W   = 19;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned CNT_W    = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Round-robin preference: which requester wins the next contended cycle.
    typedef enum logic {
        SIDE_REQ0 = 1'b0,
        SIDE_REQ1 = 1'b1
    } side_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clock      rising-edge clock
//   Regreset   asynchronous, active-high reset (empties the FIFO)
//   push       write push_data at the edge (ignored while full)
//   push_data  entry to store
//   pop        remove the head at the edge (ignored while empty)
//   pop_data   current head entry (valid while !empty)
//   full       no free slot
//   empty      no stored entry
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             Regreset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clock or posedge Regreset) begin
        if (Regreset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port (WE3/A3/WD3) between the ALU writeback
// (req0) and the load writeback (req1). Each requester feeds its own wb_fifo;
// a round-robin arbiter drains the FIFO heads into registered WE3/A3/WD3.
// A per-register pending-write counter produces the decode hazard flags.
// Ports:
//   clock, Regreset            rising-edge clock, async active-high reset
//   reqN_valid/ready/addr/data writeback request N (ready = FIFO not full)
//   rd_a1, rd_a2               decode read addresses under hazard query
//   hazard1, hazard2           read address has a pending write (combinational)
//   WE3, A3, WD3               register file write port (registered)
// Optional (macro WB_BYPASS_EN):
//   byp1_hit/byp2_hit, byp1_data/byp2_data  forward WD3 when the write being
//   presented on WE3 is the last one pending for the read address; the
//   matching hazard is suppressed.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              Regreset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [ADDR_W-1:0] rd_a1,
    input  logic [ADDR_W-1:0] rd_a2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3
`ifdef WB_BYPASS_EN
    ,
    output logic              byp1_hit,
    output logic              byp2_hit,
    output logic [DATA_W-1:0] byp1_data,
    output logic [DATA_W-1:0] byp2_data
`endif
);

    wb_entry_t         head0, head1;
    logic              full0, full1;
    logic              empty0, empty1;
    logic              push0, push1;
    logic              grant0, grant1;
    side_e             rr_q, rr_d;
    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic [CNT_W-1:0]  cnt_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d [NUM_REGS];
    logic              pend1, pend2;

    assign req0_ready = !full0;
    assign req1_ready = !full1;

    // Writes to r0 are handshaken but never queued.
    assign push0 = req0_valid && !full0 && (req0_addr != '0);
    assign push1 = req1_valid && !full1 && (req1_addr != '0);

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo0 (
        .clock     (clock),
        .Regreset  (Regreset),
        .push      (push0),
        .push_data ({req0_addr, req0_data}),
        .pop       (grant0),
        .pop_data  (head0),
        .full      (full0),
        .empty     (empty0)
    );

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo1 (
        .clock     (clock),
        .Regreset  (Regreset),
        .push      (push1),
        .push_data ({req1_addr, req1_data}),
        .pop       (grant1),
        .pop_data  (head1),
        .full      (full1),
        .empty     (empty1)
    );

    // rr_q holds the side that wins the next contended cycle; it only moves
    // when both FIFOs compete, so a lone requester never steals the turn.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        rr_d   = rr_q;
        if (!empty0 && !empty1) begin
            if (rr_q == SIDE_REQ0) begin
                grant0 = 1'b1;
                rr_d   = SIDE_REQ1;
            end else begin
                grant1 = 1'b1;
                rr_d   = SIDE_REQ0;
            end
        end else if (!empty0) begin
            grant0 = 1'b1;
        end else if (!empty1) begin
            grant1 = 1'b1;
        end
    end

    always_comb begin
        we3_d = grant0 || grant1;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (grant0) begin
            a3_d  = head0.addr;
            wd3_d = head0.data;
        end else if (grant1) begin
            a3_d  = head1.addr;
            wd3_d = head1.data;
        end
    end

    // A register stays pending from accept until the edge that commits its
    // WE3 write, so the count covers both queued and presented entries.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r]
                     + CNT_W'(push0 && (req0_addr == ADDR_W'(r)))
                     + CNT_W'(push1 && (req1_addr == ADDR_W'(r)))
                     - CNT_W'(we3_q && (a3_q == ADDR_W'(r)));
        end
    end

    always_ff @(posedge clock or posedge Regreset) begin
        if (Regreset) begin
            rr_q  <= SIDE_REQ0;
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            rr_q  <= rr_d;
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
            cnt_q <= cnt_d;
        end
    end

    assign WE3 = we3_q;
    assign A3  = a3_q;
    assign WD3 = wd3_q;

    assign pend1 = (rd_a1 != '0) && (cnt_q[rd_a1] != '0);
    assign pend2 = (rd_a2 != '0) && (cnt_q[rd_a2] != '0);

`ifdef WB_BYPASS_EN
    assign byp1_hit  = we3_q && (a3_q == rd_a1) && (rd_a1 != '0) && (cnt_q[rd_a1] == CNT_W'(1));
    assign byp2_hit  = we3_q && (a3_q == rd_a2) && (rd_a2 != '0) && (cnt_q[rd_a2] == CNT_W'(1));
    assign byp1_data = wd3_q;
    assign byp2_data = wd3_q;
    assign hazard1   = pend1 && !byp1_hit;
    assign hazard2   = pend2 && !byp2_hit;
`else
    assign hazard1   = pend1;
    assign hazard2   = pend2;
`endif

endmodule
